sync_request_arbiter: RTL and testbench

SYNC_REQUEST_ARBITER -- requirements
Module: sync_request_arbiter

---
 rtl/sync_request_arbiter.sv | 145 ++++++++++++++
 tb/tb_sync_request_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_request_arbiter.sv
// rtl/sync_request_arbiter.sv - round-robin arbiter for asynchronous request lines
// Requests are synchronized, edge-detected into a pending vector, and granted one at a time.

module bit_synchronizers #(
  parameter int WIDTH = 4
) (
  input  logic             clk_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-flop chain, deliberately unreset so the flops stay plain metastability filters.
  always_ff @(posedge clk_in) begin
    meta_q <= d_in;
    sync_q <= meta_q;
  end

  assign q_out = sync_q;

endmodule

module sync_request_arbiter #(
  parameter int WIDTH     = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [WIDTH-1:0]     reqs_in,
  input  logic                 clear_overrun_in,
  input  logic                 grant_ready_in,
  output logic                 grant_valid_out,
  output logic [IDX_WIDTH-1:0] grant_index_out,
  output logic [WIDTH-1:0]     grant_onehot_out,
  output logic [WIDTH-1:0]     pending_out,
  output logic [WIDTH-1:0]     overrun_out
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     sync_bits;
  logic [WIDTH-1:0]     prev_q;
  logic [WIDTH-1:0]     pending_q, pending_d;
  logic [WIDTH-1:0]     overrun_q, overrun_d;
  logic [IDX_WIDTH-1:0] last_ptr_q, last_ptr_d;
  logic [IDX_WIDTH-1:0] winner_q, winner_d;
  logic [IDX_WIDTH-1:0] pick;
  logic [IDX_WIDTH-1:0] pick_hi, pick_lo;
  logic                 found_hi, found_lo;
  logic                 accept;
  logic [WIDTH-1:0]     event_bits;
  logic [WIDTH-1:0]     clear_bits;
  logic [WIDTH-1:0]     overrun_set;

  bit_synchronizers #(
    .WIDTH(WIDTH)
  ) u_sync (
    .clk_in (clk_in),
    .d_in   (reqs_in),
    .q_out  (sync_bits)
  );

  assign event_bits = sync_bits & ~prev_q;

  // Round-robin: first pending line above last_ptr, otherwise wrap to the lowest pending line.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pending_q[i] && !found_lo) begin
        found_lo = 1'b1;
        pick_lo  = IDX_WIDTH'(i);
      end
      if (pending_q[i] && (i > int'(last_ptr_q)) && !found_hi) begin
        found_hi = 1'b1;
        pick_hi  = IDX_WIDTH'(i);
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    last_ptr_d = last_ptr_q;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          winner_d = pick;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (grant_ready_in) begin
          accept     = 1'b1;
          last_ptr_d = winner_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A fresh event on the line being cleared re-arms it instead of counting as lost.
  always_comb begin
    clear_bits  = accept ? (WIDTH'(1) << winner_q) : '0;
    overrun_set = event_bits & pending_q & ~clear_bits;
    pending_d   = event_bits | (pending_q & ~clear_bits);
    overrun_d   = (clear_overrun_in ? '0 : overrun_q) | overrun_set;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      prev_q     <= '1;
      pending_q  <= '0;
      overrun_q  <= '0;
      last_ptr_q <= IDX_WIDTH'(WIDTH - 1);
      winner_q   <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= sync_bits;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      last_ptr_q <= last_ptr_d;
      winner_q   <= winner_d;
    end
  end

  assign grant_valid_out  = (state_q == GRANT);
  assign grant_index_out  = winner_q;
  assign grant_onehot_out = grant_valid_out ? (WIDTH'(1) << winner_q) : '0;
  assign pending_out      = pending_q;
  assign overrun_out      = overrun_q;

endmodule

// File: tb/tb_sync_request_arbiter.sv
// tb/tb_sync_request_arbiter.sv - directed scoreboard bench for sync_request_arbiter

module tb_sync_request_arbiter;

  localparam int WIDTH     = 4;
  localparam int IDX_WIDTH = 2;

  logic                 clk;
  logic                 rst;
  logic [WIDTH-1:0]     reqs;
  logic                 clear_ovr;
  logic                 ready;
  logic                 valid;
  logic [IDX_WIDTH-1:0] index;
  logic [WIDTH-1:0]     onehot;
  logic [WIDTH-1:0]     pending;
  logic [WIDTH-1:0]     overrun;

  int compared   = 0;
  int mismatched = 0;
  int exp_q[$];

  sync_request_arbiter #(
    .WIDTH     (WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .reqs_in          (reqs),
    .clear_overrun_in (clear_ovr),
    .grant_ready_in   (ready),
    .grant_valid_out  (valid),
    .grant_index_out  (index),
    .grant_onehot_out (onehot),
    .pending_out      (pending),
    .overrun_out      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    reqs      = '0;
    ready     = 1'b0;
    clear_ovr = 1'b0;
    step(4);
    rst = 1'b0;
    step(1);
  endtask

  // Every accepted grant (valid & ready ahead of the next edge) is scored against the queue.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", {30'd0, index}, 32'hffff_ffff);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("grant_index", {30'd0, index}, e);
        check("grant_onehot", {28'd0, onehot}, 32'd1 << e);
      end
    end
  end

  initial begin
    do_reset();
    check("rst_valid", valid, 0);
    check("rst_onehot", onehot, 0);
    check("rst_pending", pending, 0);
    check("rst_overrun", overrun, 0);
    check("rst_index", index, 0);

    // Single event on line 1
    ready = 1'b1;
    reqs  = 4'b0010;
    step(2);
    check("single_pend_early", pending, 4'b0000);
    step(1);
    check("single_pend", pending, 4'b0010);
    check("single_valid_lat", valid, 0);
    exp_q.push_back(1);
    step(1);
    check("single_valid", valid, 1);
    check("single_onehot", onehot, 4'b0010);
    step(1);
    check("single_done_valid", valid, 0);
    check("single_done_pend", pending, 4'b0000);
    reqs = '0;
    step(3);

    // Round-robin from last_ptr = 3
    do_reset();
    ready = 1'b1;
    reqs  = 4'b1011;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(3);
    step(10);
    check("rr_pend_empty", pending, 0);
    check("rr_queue_drained", exp_q.size(), 0);
    reqs = '0;
    step(3);
    reqs = 4'b1001;
    exp_q.push_back(0);
    exp_q.push_back(3);
    step(10);
    check("rr2_pend_empty", pending, 0);
    check("rr2_queue_drained", exp_q.size(), 0);
    reqs = '0;
    step(3);

    // Backpressure on a line-2 grant while line 0 fires
    ready = 1'b0;
    reqs  = 4'b0100;
    exp_q.push_back(2);
    step(4);
    check("bp_valid", valid, 1);
    check("bp_index", index, 2);
    reqs = 4'b0101;
    exp_q.push_back(0);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("bp_hold_valid", valid, 1);
      check("bp_hold_index", index, 2);
    end
    check("bp_pend", pending, 4'b0101);
    ready = 1'b1;
    step(6);
    check("bp_pend_empty", pending, 0);
    check("bp_queue_drained", exp_q.size(), 0);
    reqs = '0;
    step(3);

    // Overrun on line 1
    ready = 1'b0;
    reqs  = 4'b0010;
    step(4);
    check("ovr_grant_valid", valid, 1);
    reqs = '0;
    step(3);
    reqs = 4'b0010;
    step(3);
    check("ovr_flag", overrun, 4'b0010);
    check("ovr_pend", pending, 4'b0010);
    exp_q.push_back(1);
    ready = 1'b1;
    step(4);
    check("ovr_pend_empty", pending, 0);
    check("ovr_no_second", valid, 0);
    clear_ovr = 1'b1;
    step(1);
    clear_ovr = 1'b0;
    check("ovr_cleared", overrun, 0);
    reqs = '0;
    step(3);

    // Clear and event on line 2 at the same acceptance edge
    ready = 1'b0;
    reqs  = 4'b0100;
    exp_q.push_back(2);
    exp_q.push_back(2);
    step(4);
    check("sim_valid", valid, 1);
    check("sim_index", index, 2);
    reqs = '0;
    step(3);
    reqs = 4'b0100;
    step(2);
    ready = 1'b1;
    step(1);
    check("sim_pend2", pending[2], 1);
    check("sim_ovr2", overrun[2], 0);
    check("sim_idle", valid, 0);
    step(3);
    check("sim_queue_drained", exp_q.size(), 0);
    check("sim_pend_empty", pending, 0);
    reqs = '0;
    step(3);

    // Reset during GRANT with lines held high through release
    ready = 1'b0;
    reqs  = 4'b1010;
    step(4);
    check("rg_pend", pending, 4'b1010);
    check("rg_valid", valid, 1);
    rst = 1'b1;
    step(1);
    check("rg_valid_drop", valid, 0);
    check("rg_pend_drop", pending, 0);
    step(2);
    rst   = 1'b0;
    ready = 1'b1;
    step(8);
    check("rg_no_grant", valid, 0);
    check("rg_no_pend", pending, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
